// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: combinational extraction feeding a 2-entry elastic FIFO.
// Define IMM_GEN_ILLEGAL_CHECK_EN to store and report a per-entry illegal-encoding flag on imm_err.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [2:0]       instr_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immediate,
    output logic [2:0]       out_type,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    localparam int DEPTH = 2;

    logic             s_bit;
    logic [63:0]      imm_wide;
    logic [XLEN-1:0]  imm_in;
    logic             push;
    logic             pop;
    logic [1:0]       count_reg, count_next;
    logic             wr_ptr_reg, wr_ptr_next;
    logic             rd_ptr_reg, rd_ptr_next;
    logic [XLEN-1:0]  ent_imm  [DEPTH];
    logic [2:0]       ent_type [DEPTH];
    logic [TAG_W-1:0] ent_tag  [DEPTH];

    // Build every format at 64 bits and truncate, so XLEN=32 needs no zero-width replications.
    always_comb begin
        s_bit    = instruction[31];
        imm_wide = '0;
        case (instr_type)
            3'b000: imm_wide = {{52{s_bit}}, instruction[31:20]};
            3'b001: imm_wide = {{52{s_bit}}, instruction[31:25], instruction[11:7]};
            3'b010: imm_wide = {{32{s_bit}}, instruction[31:12], 12'b0};
            3'b011: imm_wide = (XLEN == 64) ? {58'b0, instruction[25:20]}
                                            : {59'b0, instruction[24:20]};
            3'b100: imm_wide = {59'b0, instruction[19:15]};
            3'b101: imm_wide = {{51{s_bit}}, instruction[31], instruction[7],
                                instruction[30:25], instruction[11:8], 1'b0};
            3'b110: imm_wide = {{43{s_bit}}, instruction[31], instruction[19:12],
                                instruction[20], instruction[30:21], 1'b0};
            default: imm_wide = '0;
        endcase
    end

    assign imm_in = imm_wide[XLEN-1:0];

    // Opcode bits only matter to the optional check; upper bits of imm_wide vanish at XLEN=32.
    logic unused_bits;
    assign unused_bits = ^{imm_wide, instruction[6:0]};

    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            count_next  = 2'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
        end else begin
            if (push) wr_ptr_next = ~wr_ptr_reg;
            if (pop)  rd_ptr_next = ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

`ifdef IMM_GEN_ILLEGAL_CHECK_EN
    logic err_in;
    logic ent_err [DEPTH];
    assign err_in = (instr_type == 3'b111) | (instruction[1:0] != 2'b11) |
                    ((XLEN == 32) & (instr_type == 3'b011) & instruction[25]);
`endif

    // Data registers are cleared only by rst so the head reads back 0/111/0 after reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [XLEN-1:0]  imm_reg;
            logic [2:0]       type_reg;
            logic [TAG_W-1:0] tag_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    imm_reg  <= '0;
                    type_reg <= 3'b111;
                    tag_reg  <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    imm_reg  <= imm_in;
                    type_reg <= instr_type;
                    tag_reg  <= in_tag;
                end
            end

            assign ent_imm[gi]  = imm_reg;
            assign ent_type[gi] = type_reg;
            assign ent_tag[gi]  = tag_reg;

`ifdef IMM_GEN_ILLEGAL_CHECK_EN
            logic err_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    err_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    err_reg <= err_in;
                end
            end
            assign ent_err[gi] = err_reg;
`endif
        end
    endgenerate

    assign immediate = ent_imm[rd_ptr_reg];
    assign out_type  = ent_type[rd_ptr_reg];
    assign out_tag   = ent_tag[rd_ptr_reg];

`ifdef IMM_GEN_ILLEGAL_CHECK_EN
    assign imm_err = out_valid & ent_err[rd_ptr_reg];
`else
    assign imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe at XLEN=32: vector table plus handshake, flush and reset sequences.
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic [2:0]       instr_type;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immediate;
    logic [2:0]       out_type;
    logic [TAG_W-1:0] out_tag;
    logic             imm_err;

    int checks   = 0;
    int failures = 0;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .instr_type(instr_type), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .immediate(immediate), .out_type(out_type), .out_tag(out_tag),
        .imm_err(imm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  typ;
        logic [31:0] tag;
        logic [31:0] exp_imm;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] instr, input logic [2:0] typ);
`ifdef IMM_GEN_ILLEGAL_CHECK_EN
        return (typ == 3'b111) || (instr[1:0] != 2'b11) || ((typ == 3'b011) && instr[25]);
`else
        return 1'b0;
`endif
    endfunction

    // Advance one edge; inputs are then changed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] t, input logic [31:0] tg);
        in_valid    = v;
        instruction = ins;
        instr_type  = t;
        in_tag      = tg;
    endtask

    int          pushed;
    logic [31:0] got [$];

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'b000, 32'h10, 32'hFFFFFFFF};
        vecs[1]  = '{32'h7FF00093, 3'b000, 32'h11, 32'h000007FF};
        vecs[2]  = '{32'hFE112E23, 3'b001, 32'h12, 32'hFFFFFFFC};
        vecs[3]  = '{32'h123450B7, 3'b010, 32'h13, 32'h12345000};
        vecs[4]  = '{32'h01F09093, 3'b011, 32'h14, 32'h0000001F};
        vecs[5]  = '{32'h02509093, 3'b011, 32'h15, 32'h00000005};
        vecs[6]  = '{32'h3407D073, 3'b100, 32'h16, 32'h0000000F};
        vecs[7]  = '{32'hFE000EE3, 3'b101, 32'h17, 32'hFFFFFFFC};
        vecs[8]  = '{32'h0080006F, 3'b110, 32'h18, 32'h00000008};
        vecs[9]  = '{32'h12345678, 3'b111, 32'h19, 32'h00000000};
        vecs[10] = '{32'h00000000, 3'b000, 32'h1A, 32'h00000000};
        vecs[11] = '{32'h800000B7, 3'b010, 32'h1B, 32'h80000000};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        step(); step();
        rst = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_immediate", 64'(immediate), 64'd0);
        chk("reset_out_type", 64'(out_type), 64'd7);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        chk("reset_imm_err", 64'(imm_err), 64'd0);

        // Table: one push per vector, checked one cycle later, then drained.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].typ, vecs[i].tag);
            step();
            drive(1'b0, 32'h0, 3'b000, 32'h0);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_imm", i), 64'(immediate), 64'(vecs[i].exp_imm));
            chk($sformatf("vec%0d_type", i), 64'(out_type), 64'(vecs[i].typ));
            chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
            chk($sformatf("vec%0d_err", i), 64'(imm_err), 64'(exp_err(vecs[i].instr, vecs[i].typ)));
            $display("vec %0d instr=0x%08h type=%0d imm=0x%08h tag=0x%0h", i, vecs[i].instr, vecs[i].typ, immediate, out_tag);
            step();
            chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
        end

        // B then J back-to-back, streaming at one per cycle.
        drive(1'b1, 32'hFE000EE3, 3'b101, 32'hB0);
        step();
        drive(1'b1, 32'h0080006F, 3'b110, 32'hB1);
        chk("bj_first_imm", 64'(immediate), 64'hFFFFFFFC);
        chk("bj_first_tag", 64'(out_tag), 64'hB0);
        step();
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        chk("bj_second_valid", 64'(out_valid), 64'd1);
        chk("bj_second_imm", 64'(immediate), 64'h8);
        chk("bj_second_tag", 64'(out_tag), 64'hB1);
        $display("stream B/J tags 0xB0,0xB1 delivered");
        step();

        // Backpressure: three pushes against a stalled consumer, released after cycle 4.
        out_ready = 1'b0;
        pushed = 0;
        got.delete();
        drive(1'b1, 32'h00100093, 3'b000, 32'd1);
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 3) begin
                chk("bp_in_ready_full", 64'(in_ready), 64'd0);
                chk("bp_head_tag_held", 64'(out_tag), 64'd1);
            end
            if (cyc == 4) out_ready = 1'b1;
            if (out_valid && out_ready) got.push_back(out_tag);
            if (in_valid && in_ready) pushed++;
            step();
            if (pushed < 3) drive(1'b1, 32'h00100093, 3'b000, 32'(pushed + 1));
            else drive(1'b0, 32'h0, 3'b000, 32'h0);
        end
        chk("bp_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_order%0d", i), (i < got.size()) ? 64'(got[i]) : 64'hDEAD, 64'(i + 1));
        end
        $display("backpressure delivered %0d entries", got.size());

        // Simultaneous push/pop at count 1.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'b000, 32'd100);
        step();
        for (int i = 1; i <= 10; i++) begin
            out_ready = 1'b1;
            drive(1'b1, 32'h00100093, 3'b000, 32'(100 + i));
            step();
            chk($sformatf("pp%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("pp%0d_in_ready", i), 64'(in_ready), 64'd1);
            chk($sformatf("pp%0d_tag", i), 64'(out_tag), 64'(100 + i));
        end
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        step();
        chk("pp_drained", 64'(out_valid), 64'd0);
        $display("push/pop at count 1 ran 10 cycles");

        // Flush while full with a concurrent push.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'b000, 32'd201);
        step();
        drive(1'b1, 32'h00100093, 3'b000, 32'd202);
        step();
        chk("fl_full", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h00100093, 3'b000, 32'h99);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("fl_no_ghost%0d", i), 64'(out_valid), 64'd0);
        end
        $display("flush with count=2 emptied the buffer");

        // Flush with an empty buffer must also drop the concurrent push.
        drive(1'b1, 32'h00100093, 3'b000, 32'h98);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        chk("fl_empty_drop", 64'(out_valid), 64'd0);

        // Reset mid-stream.
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'b000, 32'd301);
        step();
        drive(1'b1, 32'h0080006F, 3'b110, 32'd302);
        step();
        drive(1'b1, 32'h123450B7, 3'b010, 32'd303);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_immediate", 64'(immediate), 64'd0);
        chk("rst_mid_out_type", 64'(out_type), 64'd7);
        chk("rst_mid_out_tag", 64'(out_tag), 64'd0);
        chk("rst_mid_imm_err", 64'(imm_err), 64'd0);
        $display("mid-stream reset cleared the buffer");

        // First push after reset comes from entry 0 again.
        out_ready = 1'b1;
        drive(1'b1, 32'h01F09093, 3'b011, 32'd401);
        step();
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        chk("post_rst_imm", 64'(immediate), 64'h1F);
        chk("post_rst_tag", 64'(out_tag), 64'd401);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
